// File: rtl/marlann_top.sv
// MARLANN QPI slave: synchronised nibble-serial front end in front of a single-port
// byte memory, with write (0x20), read (0x21, one dummy byte) and status (0x22) commands.
module marlann_top #(
   parameter int MEM_ABITS   = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic qpi_csb,
   input  logic qpi_clk,
   inout  wire  qpi_io0,
   inout  wire  qpi_io1,
   inout  wire  qpi_io2,
   inout  wire  qpi_io3,
   output logic qpi_rdy,
   output logic qpi_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR_HI = 3'd2,
      ADDR_LO = 3'd3,
      DUMMY   = 3'd4,
      WDATA   = 3'd5,
      RDATA   = 3'd6,
      STATUS  = 3'd7
   } state_t;

   localparam logic [7:0] CMD_WRITE  = 8'h20;
   localparam logic [7:0] CMD_READ   = 8'h21;
   localparam logic [7:0] CMD_STATUS = 8'h22;

   function automatic logic [7:0] status_byte(input logic err);
      return {6'b000000, err, 1'b0};
   endfunction

   logic [SYNC_STAGES-1:0]      csb_sync_r;
   logic [SYNC_STAGES-1:0]      clk_sync_r;
   logic [SYNC_STAGES-1:0][3:0] io_sync_r;
   logic                        csb_prev_r;
   logic                        clk_prev_r;
   logic [SYNC_STAGES:0]        settle_r;
   logic                        armed_r;

   logic       csb_s;
   logic       clk_s;
   logic [3:0] io_s;
   logic       csb_fall_s;
   logic       csb_rise_s;
   logic       qclk_rise_s;
   logic       qclk_fall_s;

   state_t                 state_r, state_next_s;
   logic                   nib_r, nib_next_s;
   logic [3:0]             hi_r, hi_next_s;
   logic [7:0]             addr_hi_r, addr_hi_next_s;
   logic [MEM_ABITS-1:0]   addr_r, addr_next_s;
   logic                   is_write_r, is_write_next_s;
   logic                   err_r, err_next_s;
   logic                   io_oe_r, oe_next_s;
   logic [3:0]             io_out_r, out_next_s;
   logic                   stat_full_r, stat_full_next_s;

   logic [7:0]             mem [0:(2**MEM_ABITS)-1];
   logic [7:0]             rd_data_r;
   logic                   mem_we_s;
   logic [7:0]             mem_wdata_s;
   logic [7:0]             byte_s;
   logic                   byte_done_s;
   logic [7:0]             src_byte_s;

   assign csb_s = csb_sync_r[SYNC_STAGES-1];
   assign clk_s = clk_sync_r[SYNC_STAGES-1];
   assign io_s  = io_sync_r[SYNC_STAGES-1];

   // Edges only count once the chain holds real samples, so a csb held low through
   // reset is never mistaken for a fresh falling edge.
   assign csb_fall_s  = armed_r & csb_prev_r & ~csb_s;
   assign csb_rise_s  = ~csb_prev_r & csb_s;
   assign qclk_rise_s = ~csb_s & ~clk_prev_r & clk_s;
   assign qclk_fall_s = ~csb_s & clk_prev_r & ~clk_s;

   // input synchronisers and edge-detect history, reset to the idle bus levels
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         csb_sync_r <= '1;
         clk_sync_r <= '0;
         io_sync_r  <= '0;
         csb_prev_r <= 1'b1;
         clk_prev_r <= 1'b0;
         settle_r   <= '0;
         armed_r    <= 1'b0;
      end else begin
         csb_sync_r[0] <= qpi_csb;
         clk_sync_r[0] <= qpi_clk;
         io_sync_r[0]  <= {qpi_io3, qpi_io2, qpi_io1, qpi_io0};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            csb_sync_r[i] <= csb_sync_r[i-1];
            clk_sync_r[i] <= clk_sync_r[i-1];
            io_sync_r[i]  <= io_sync_r[i-1];
         end
         csb_prev_r <= csb_s;
         clk_prev_r <= clk_s;
         settle_r   <= {settle_r[SYNC_STAGES-1:0], 1'b1};
         if (settle_r[SYNC_STAGES] && csb_s) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   // next-state and datapath decode; at most one bus event arrives per cycle
   always_comb begin
      state_next_s     = state_r;
      nib_next_s       = nib_r;
      hi_next_s        = hi_r;
      addr_hi_next_s   = addr_hi_r;
      addr_next_s      = addr_r;
      is_write_next_s  = is_write_r;
      err_next_s       = err_r;
      oe_next_s        = io_oe_r;
      out_next_s       = io_out_r;
      stat_full_next_s = stat_full_r;
      mem_we_s         = 1'b0;
      mem_wdata_s      = 8'h00;
      byte_s           = {hi_r, io_s};
      byte_done_s      = 1'b0;
      src_byte_s       = (state_r == STATUS) ? status_byte(err_r) : rd_data_r;

      if (csb_rise_s) begin
         state_next_s = IDLE;
         nib_next_s   = 1'b0;
         oe_next_s    = 1'b0;
         if (nib_r && (state_r == CMD || state_r == ADDR_HI ||
                       state_r == ADDR_LO || state_r == WDATA)) begin
            err_next_s = 1'b1;
         end else if (state_r == STATUS && stat_full_r) begin
            err_next_s = 1'b0;
         end else begin
            err_next_s = err_r;
         end
      end else if (csb_fall_s) begin
         state_next_s     = CMD;
         nib_next_s       = 1'b0;
         oe_next_s        = 1'b0;
         stat_full_next_s = 1'b0;
      end else if (qclk_rise_s) begin
         case (state_r)
            CMD, ADDR_HI, ADDR_LO, DUMMY, WDATA: begin
               if (nib_r) begin
                  nib_next_s  = 1'b0;
                  byte_done_s = 1'b1;
               end else begin
                  nib_next_s = 1'b1;
                  hi_next_s  = io_s;
               end
            end
            // the master sampling the low nibble completes a status byte
            STATUS: begin
               if (io_oe_r && !nib_r) begin
                  stat_full_next_s = 1'b1;
               end else begin
                  stat_full_next_s = stat_full_r;
               end
            end
            default: nib_next_s = nib_r;
         endcase

         if (byte_done_s) begin
            case (state_r)
               CMD: begin
                  case (byte_s)
                     CMD_WRITE: begin
                        is_write_next_s = 1'b1;
                        state_next_s    = ADDR_HI;
                     end
                     CMD_READ: begin
                        is_write_next_s = 1'b0;
                        state_next_s    = ADDR_HI;
                     end
                     CMD_STATUS: state_next_s = STATUS;
                     default: begin
                        err_next_s   = 1'b1;
                        state_next_s = IDLE;
                     end
                  endcase
               end
               ADDR_HI: begin
                  addr_hi_next_s = byte_s;
                  state_next_s   = ADDR_LO;
               end
               ADDR_LO: begin
                  addr_next_s  = MEM_ABITS'({addr_hi_r, byte_s});
                  state_next_s = is_write_r ? WDATA : DUMMY;
               end
               DUMMY: state_next_s = RDATA;
               WDATA: begin
                  mem_we_s    = 1'b1;
                  mem_wdata_s = byte_s;
                  addr_next_s = addr_r + MEM_ABITS'(1);
               end
               default: state_next_s = state_r;
            endcase
         end else begin
            state_next_s = state_next_s;
         end
      end else if (qclk_fall_s) begin
         if (state_r == RDATA || state_r == STATUS) begin
            oe_next_s = 1'b1;
            if (nib_r) begin
               out_next_s = src_byte_s[3:0];
               nib_next_s = 1'b0;
               if (state_r == RDATA) begin
                  addr_next_s = addr_r + MEM_ABITS'(1);
               end else begin
                  addr_next_s = addr_r;
               end
            end else begin
               out_next_s = src_byte_s[7:4];
               nib_next_s = 1'b1;
            end
         end else begin
            oe_next_s = io_oe_r;
         end
      end else begin
         state_next_s = state_r;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= IDLE;
         nib_r       <= 1'b0;
         hi_r        <= 4'h0;
         addr_hi_r   <= 8'h00;
         addr_r      <= '0;
         is_write_r  <= 1'b0;
         err_r       <= 1'b0;
         io_oe_r     <= 1'b0;
         io_out_r    <= 4'h0;
         stat_full_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         nib_r       <= nib_next_s;
         hi_r        <= hi_next_s;
         addr_hi_r   <= addr_hi_next_s;
         addr_r      <= addr_next_s;
         is_write_r  <= is_write_next_s;
         err_r       <= err_next_s;
         io_oe_r     <= oe_next_s;
         io_out_r    <= out_next_s;
         stat_full_r <= stat_full_next_s;
      end
   end

   // Single-port memory: read data tracks addr_r a cycle later, well before the next qpi_clk fall.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem[addr_r] <= mem_wdata_s;
      end
      rd_data_r <= mem[addr_r];
   end

   assign qpi_io0 = io_oe_r ? io_out_r[0] : 1'bz;
   assign qpi_io1 = io_oe_r ? io_out_r[1] : 1'bz;
   assign qpi_io2 = io_oe_r ? io_out_r[2] : 1'bz;
   assign qpi_io3 = io_oe_r ? io_out_r[3] : 1'bz;

   assign qpi_rdy = (state_r == IDLE) && csb_s;
   assign qpi_err = err_r;

endmodule

// File: tb/tb_marlann_top.sv
// Self-checking bench for marlann_top: a QPI master model, a command table, directed
// corner sequences and randomised write/read traffic checked against a byte-array model.
module tb_marlann_top;

   localparam int HALF = 6;

   typedef struct {
      logic [7:0] cmd;
      logic       exp_err;
   } cmd_vec_t;

   logic       clock   = 1'b0;
   logic       resetn  = 1'b0;
   logic       qpi_csb = 1'b1;
   logic       qpi_clk = 1'b0;
   logic       tb_oe   = 1'b0;
   logic [3:0] tb_io   = 4'h0;
   wire        qpi_io0, qpi_io1, qpi_io2, qpi_io3;
   logic       qpi_rdy, qpi_err;

   assign qpi_io0 = tb_oe ? tb_io[0] : 1'bz;
   assign qpi_io1 = tb_oe ? tb_io[1] : 1'bz;
   assign qpi_io2 = tb_oe ? tb_io[2] : 1'bz;
   assign qpi_io3 = tb_oe ? tb_io[3] : 1'bz;

   marlann_top #(.MEM_ABITS(10), .SYNC_STAGES(2)) dut (
      .clock   (clock),
      .resetn  (resetn),
      .qpi_csb (qpi_csb),
      .qpi_clk (qpi_clk),
      .qpi_io0 (qpi_io0),
      .qpi_io1 (qpi_io1),
      .qpi_io2 (qpi_io2),
      .qpi_io3 (qpi_io3),
      .qpi_rdy (qpi_rdy),
      .qpi_err (qpi_err)
   );

   always #5 clock = ~clock;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] mem_model [1024];
   bit         mem_known [1024];
   bit         in_write = 1'b0;
   int         wr_drive_cnt = 0;

   // any cycle the slave drives the bus during a write command is a violation
   always @(negedge clock) begin
      if (in_write && dut.io_oe_r) wr_drive_cnt++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic begin_txn();
      qpi_csb = 1'b0;
      cyc(HALF);
   endtask

   task automatic end_txn();
      tb_oe = 1'b0;
      cyc(HALF);
      qpi_csb = 1'b1;
      cyc(HALF);
   endtask

   task automatic send_nib(input logic [3:0] n);
      tb_oe = 1'b1;
      tb_io = n;
      cyc(HALF);
      qpi_clk = 1'b1;
      cyc(HALF);
      qpi_clk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      tb_oe = 1'b0;
      cyc(HALF);
      b[7:4] = {qpi_io3, qpi_io2, qpi_io1, qpi_io0};
      qpi_clk = 1'b1;
      cyc(HALF);
      qpi_clk = 1'b0;
      cyc(HALF);
      b[3:0] = {qpi_io3, qpi_io2, qpi_io1, qpi_io0};
      qpi_clk = 1'b1;
      cyc(HALF);
      qpi_clk = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d [4], input int n);
      int idx;
      in_write = 1'b1;
      begin_txn();
      send_byte(8'h20);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      for (int i = 0; i < n; i++) begin
         send_byte(d[i]);
         idx = (int'(a[9:0]) + i) % 1024;
         mem_model[idx] = d[i];
         mem_known[idx] = 1'b1;
      end
      end_txn();
      in_write = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a, input int n, output logic [7:0] q [4]);
      begin_txn();
      send_byte(8'h21);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(8'h00);
      for (int i = 0; i < n; i++) recv_byte(q[i]);
      end_txn();
   endtask

   task automatic status_read(output logic [7:0] b);
      begin_txn();
      send_byte(8'h22);
      recv_byte(b);
      end_txn();
   endtask

   initial begin : main
      cmd_vec_t   vecs [7];
      logic [7:0] b;
      logic [7:0] q [4];
      logic [7:0] d [4];
      logic [15:0] a;
      logic [15:0] last_a;
      int          n;
      int          idx;
      bit          err_model;

      vecs[0] = '{cmd: 8'h20, exp_err: 1'b0};
      vecs[1] = '{cmd: 8'h21, exp_err: 1'b0};
      vecs[2] = '{cmd: 8'h22, exp_err: 1'b0};
      vecs[3] = '{cmd: 8'h7E, exp_err: 1'b1};
      vecs[4] = '{cmd: 8'h00, exp_err: 1'b1};
      vecs[5] = '{cmd: 8'hFF, exp_err: 1'b1};
      vecs[6] = '{cmd: 8'h23, exp_err: 1'b1};
      err_model = 1'b0;
      last_a = 16'h0000;

      // reset state
      cyc(3);
      check("reset_err", {31'd0, qpi_err}, 32'd0);
      check("reset_oe", {31'd0, dut.io_oe_r}, 32'd0);
      resetn = 1'b1;
      cyc(1);
      check("rdy_after_reset", {31'd0, qpi_rdy}, 32'd1);
      cyc(HALF);

      // rdy drop on csb, then write 20 00 10 AA 55 and read it back
      qpi_csb = 1'b0;
      cyc(3);
      check("rdy_low_in_txn", {31'd0, qpi_rdy}, 32'd0);
      cyc(HALF - 3);
      in_write = 1'b1;
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'hAA);
      send_byte(8'h55);
      end_txn();
      in_write = 1'b0;
      mem_model[16] = 8'hAA; mem_known[16] = 1'b1;
      mem_model[17] = 8'h55; mem_known[17] = 1'b1;
      check("rdy_after_write", {31'd0, qpi_rdy}, 32'd1);
      check("write_bus_hiz", wr_drive_cnt, 32'd0);
      do_read(16'h0010, 2, q);
      check("rd_0010_b0", {24'd0, q[0]}, 32'hAA);
      check("rd_0010_b1", {24'd0, q[1]}, 32'h55);
      check("err_after_rw", {31'd0, qpi_err}, 32'd0);

      // address wrap at the top of memory; upper address bits ignored
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h00; d[3] = 8'h00;
      do_write(16'h03FF, d, 2);
      do_read(16'h03FF, 2, q);
      check("wrap_rd_b0", {24'd0, q[0]}, 32'h11);
      check("wrap_rd_b1", {24'd0, q[1]}, 32'h22);
      do_read(16'hFC00, 1, q);
      check("upper_addr_ignored", {24'd0, q[0]}, 32'h22);

      // command table: unknown commands flag an error that a status read reports and clears
      foreach (vecs[i]) begin
         begin_txn();
         send_byte(vecs[i].cmd);
         end_txn();
         check($sformatf("cmd_%02h_err", vecs[i].cmd), {31'd0, qpi_err}, {31'd0, vecs[i].exp_err});
         status_read(b);
         check($sformatf("cmd_%02h_status", vecs[i].cmd), {24'd0, b},
               {24'd0, 6'b000000, vecs[i].exp_err, 1'b0});
         check($sformatf("cmd_%02h_cleared", vecs[i].cmd), {31'd0, qpi_err}, 32'd0);
      end
      status_read(b);
      check("status_clean", {24'd0, b}, 32'h00);

      // bytes after a bad command must not reach memory
      begin_txn();
      send_byte(8'h7E);
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'hAB);
      end_txn();
      check("bad_cmd_err", {31'd0, qpi_err}, 32'd1);
      do_read(16'h0000, 1, q);
      check("bad_cmd_no_write", {24'd0, q[0]}, {24'd0, mem_model[0]});
      status_read(b);
      check("bad_cmd_status", {24'd0, b}, 32'h02);

      // partial write byte is discarded and flagged
      in_write = 1'b1;
      begin_txn();
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h00);
      send_nib(4'hC);
      end_txn();
      in_write = 1'b0;
      check("odd_nib_err", {31'd0, qpi_err}, 32'd1);
      do_read(16'h0000, 1, q);
      check("odd_nib_mem", {24'd0, q[0]}, {24'd0, mem_model[0]});
      status_read(b);
      check("odd_nib_status", {24'd0, b}, 32'h02);
      check("odd_nib_cleared", {31'd0, qpi_err}, 32'd0);

      // odd nibble count during a read is not an error
      begin_txn();
      send_byte(8'h21);
      send_byte(8'h00);
      send_byte(8'h10);
      send_nib(4'h0);
      end_txn();
      check("odd_dummy_no_err", {31'd0, qpi_err}, 32'd0);

      // reset in the middle of RDATA
      begin_txn();
      send_byte(8'h21);
      send_byte(8'h03);
      send_byte(8'hFF);
      send_byte(8'h00);
      tb_oe = 1'b0;
      cyc(HALF);
      check("rdata_driving", {31'd0, dut.io_oe_r}, 32'd1);
      check("rdata_hi_nib", {28'd0, qpi_io3, qpi_io2, qpi_io1, qpi_io0}, 32'h1);
      qpi_clk = 1'b1;
      cyc(2);
      resetn  = 1'b0;
      qpi_clk = 1'b0;
      qpi_csb = 1'b1;
      #1;
      check("reset_releases_bus", {31'd0, dut.io_oe_r}, 32'd0);
      cyc(3);
      resetn = 1'b1;
      cyc(1);
      check("rdy_after_mid_reset", {31'd0, qpi_rdy}, 32'd1);
      check("err_after_mid_reset", {31'd0, qpi_err}, 32'd0);
      cyc(HALF);
      do_read(16'h03FF, 2, q);
      check("post_reset_rd_b0", {24'd0, q[0]}, 32'h11);
      check("post_reset_rd_b1", {24'd0, q[1]}, 32'h22);

      // randomised traffic against the byte-array model
      for (int k = 0; k < 24; k++) begin
         a = 16'($urandom);
         n = int'($urandom_range(1, 4));
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            do_write(a, d, n);
            last_a = a;
         end else begin
            if ($urandom_range(0, 2) != 0) a = last_a;
            do_read(a, n, q);
            for (int i = 0; i < n; i++) begin
               idx = (int'(a[9:0]) + i) % 1024;
               if (mem_known[idx]) check($sformatf("rand_rd_%03h", idx), {24'd0, q[i]},
                                         {24'd0, mem_model[idx]});
            end
         end
         check("rand_err", {31'd0, qpi_err}, {31'd0, err_model});
      end
      check("write_bus_hiz_all", wr_drive_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
